// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg : shared key width, key range and debounce FSM encoding
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

   localparam int KEY_W   = 4;
   localparam int KEY_MAX = 9;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_t;

endpackage

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ----------------------------------------------------------------------------
// keypad_debounce : 2-flop synchronizer plus press/release debounce FSM;
//                   emits a one-cycle accept strobe with the accepted digit
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [KEY_W-1:0] i_number,
   output logic             o_accept,
   output logic [KEY_W-1:0] o_accept_digit
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_valid_m, r_valid_s;
   logic [KEY_W-1:0] r_num_m, r_num_s;
   kp_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [KEY_W-1:0] r_cand, w_cand_nxt;
   logic             w_kv;

   // Codes above KEY_MAX are decoder noise and count as "no key"
   assign w_kv = r_valid_s && (r_num_s <= KEY_W'(KEY_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_m <= 1'b0;
         r_valid_s <= 1'b0;
         r_num_m   <= '0;
         r_num_s   <= '0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_cand    <= '0;
      end else begin
         r_valid_m <= i_valid;
         r_valid_s <= r_valid_m;
         r_num_m   <= i_number;
         r_num_s   <= r_num_m;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cand    <= w_cand_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      o_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_kv) begin
               w_cand_nxt  = r_num_s;
               w_cnt_nxt   = '0;
               w_state_nxt = PRESS_DB;
            end
         end
         PRESS_DB: begin
            if (!w_kv || (r_num_s != r_cand)) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = HELD;
               o_accept    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         HELD: begin
            // No auto-repeat: value changes while held are ignored
            if (!w_kv) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RELEASE_DB;
            end
         end
         RELEASE_DB: begin
            if (w_kv) begin
               w_state_nxt = HELD;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_accept_digit = r_cand;

endmodule

`default_nettype wire

// File: rtl/keypad_entry.sv
// ----------------------------------------------------------------------------
// keypad_entry : debounced keypad digits shifted into a BCD entry buffer,
//                handed downstream with a ready/ack handshake
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               valid,
   input  logic [KEY_W-1:0]                   number,
   input  logic                               ack,
   output logic [KEY_W*NUM_DIGITS-1:0]        digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]    count,
   output logic                               ready,
   output logic                               key_event,
   output logic                               dropped
);

   localparam int BUF_W = KEY_W * NUM_DIGITS;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);

   logic             w_accept;
   logic [KEY_W-1:0] w_accept_digit;

   logic [BUF_W-1:0] r_digits;
   logic [CNT_W-1:0] r_count;
   logic             r_ready;
   logic             r_key_event;
   logic             r_dropped;

   logic             w_clear;
   logic [BUF_W-1:0] w_base_digits;
   logic [CNT_W-1:0] w_base_count;
   logic [BUF_W-1:0] w_shifted;
   logic [CNT_W-1:0] w_count_inc;

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk            (clk),
      .reset          (reset),
      .i_valid        (valid),
      .i_number       (number),
      .o_accept       (w_accept),
      .o_accept_digit (w_accept_digit)
   );

   // A same-cycle ack empties the buffer before the new digit lands
   assign w_clear       = ack && r_ready;
   assign w_base_digits = w_clear ? '0 : r_digits;
   assign w_base_count  = w_clear ? '0 : r_count;
   assign w_count_inc   = w_base_count + 1'b1;

   generate
      if (NUM_DIGITS == 1) begin : g_load
         assign w_shifted = w_accept_digit;
      end else begin : g_shift
         assign w_shifted = {w_base_digits[BUF_W-KEY_W-1:0], w_accept_digit};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_digits    <= '0;
         r_count     <= '0;
         r_ready     <= 1'b0;
         r_key_event <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         r_key_event <= 1'b0;
         r_dropped   <= 1'b0;
         if (w_accept && r_ready && !ack) begin
            r_dropped <= 1'b1;
         end else if (w_accept) begin
            r_digits    <= w_shifted;
            r_count     <= w_count_inc;
            r_ready     <= (w_count_inc == CNT_W'(NUM_DIGITS));
            r_key_event <= 1'b1;
         end else if (w_clear) begin
            r_digits <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
         end
      end
   end

   assign digits    = r_digits;
   assign count     = r_count;
   assign ready     = r_ready;
   assign key_event = r_key_event;
   assign dropped   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ----------------------------------------------------------------------------
// tb_keypad_entry : directed + randomized bench for keypad_entry against a
//                   run-length / queue reference model
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_entry;

   localparam int N = 4;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [3:0]  number;
   logic        ack;
   logic [15:0] digits;
   logic [2:0]  count;
   logic        ready;
   logic        key_event;
   logic        dropped;

   int n_tests = 0;
   int n_fail  = 0;
   int ev_cnt  = 0;
   logic chk_en   = 1'b0;
   logic rand_ack = 1'b0;

   // reference model state
   int s1v = 0, s2v = 0, s1n = 0, s2n = 0;
   int m_held = 0, m_run = 0, m_rel = 0, m_rn = 0;
   int q[$];
   logic [15:0] exp_digits = '0;
   int          exp_count  = 0;
   logic        exp_ready  = 1'b0;
   logic        exp_ev     = 1'b0;
   logic        exp_drop   = 1'b0;

   keypad_entry #(
      .NUM_DIGITS      (N),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .number    (number),
      .ack       (ack),
      .digits    (digits),
      .count     (count),
      .ready     (ready),
      .key_event (key_event),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A press is accepted after D+1 consecutive samples of the same valid
   // digit while released; release needs D+1 consecutive no-key samples.
   task automatic model_step();
      logic kv, acc, full, clr;
      if (reset) begin
         s1v = 0; s2v = 0; s1n = 0; s2n = 0;
         m_held = 0; m_run = 0; m_rel = 0; m_rn = 0;
         q.delete();
         exp_ev = 1'b0; exp_drop = 1'b0;
      end else begin
         kv  = (s2v != 0) && (s2n <= 9);
         acc = 1'b0;
         if (m_held == 0) begin
            if (m_run == 0) begin
               if (kv) begin m_run = 1; m_rn = s2n; end
            end else if (kv && s2n == m_rn) begin
               m_run++;
               if (m_run == D + 1) begin acc = 1'b1; m_held = 1; m_rel = 0; m_run = 0; end
            end else begin
               m_run = 0;
            end
         end else begin
            if (kv) m_rel = 0;
            else begin
               m_rel++;
               if (m_rel == D + 1) begin m_held = 0; m_rel = 0; m_run = 0; end
            end
         end
         full = (q.size() == N);
         clr  = ack && full;
         exp_ev = 1'b0; exp_drop = 1'b0;
         if (acc) begin
            if (full && !ack) exp_drop = 1'b1;
            else begin
               if (clr) q.delete();
               q.push_back(m_rn);
               exp_ev = 1'b1;
            end
         end else if (clr) begin
            q.delete();
         end
         s2v = s1v; s2n = s1n;
         s1v = int'(valid); s1n = int'(number);
      end
      exp_digits = '0;
      foreach (q[i]) exp_digits = {exp_digits[11:0], 4'(q[i])};
      exp_count = q.size();
      exp_ready = (q.size() == N);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         if (rand_ack) ack = ($urandom_range(0, 5) == 0);
      end
   endtask

   task automatic press(input int num, input int hold, input int rel);
      valid = 1'b1; number = 4'(num);
      tick(hold);
      valid = 1'b0; number = 4'($urandom_range(0, 15));
      tick(rel);
   endtask

   task automatic measure_latency(input string tag);
      int lat;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (key_event === 1'b1) begin lat = i - 1; break; end
      end
      check(tag, lat, 2 + D);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("digits", digits, exp_digits);
         check("count", count, exp_count);
         check("ready", ready, exp_ready);
         check("key_event", key_event, exp_ev);
         check("dropped", dropped, exp_drop);
         if (key_event === 1'b1) ev_cnt <= ev_cnt + 1;
      end
   end

   initial begin
      int e0, r;
      reset = 1'b1; valid = 1'b0; number = '0; ack = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      reset = 1'b0;
      check("rst_digits", digits, 16'h0);
      check("rst_ready", ready, 1'b0);

      // clean press 5 with latency measurement
      valid = 1'b1; number = 4'd5;
      measure_latency("latency");
      tick(12);
      valid = 1'b0;
      tick(10);
      check("press5_digit", digits[3:0], 4'd5);
      check("press5_count", count, 3'd1);

      reset = 1'b1; tick(2); reset = 1'b0;

      // fill, overflow drop, then ack
      press(1, 10, 10); press(2, 10, 10); press(3, 10, 10); press(4, 10, 10);
      check("fill_digits", digits, 16'h1234);
      check("fill_ready", ready, 1'b1);
      e0 = ev_cnt;
      press(7, 10, 10);
      check("drop_digits", digits, 16'h1234);
      check("drop_noevent", ev_cnt - e0, 0);
      ack = 1'b1; tick(1); ack = 1'b0;
      check("ack_digits", digits, 16'h0);
      check("ack_count", count, 3'd0);

      // bouncy press of 8 then glitchy release
      e0 = ev_cnt;
      number = 4'd8;
      valid = 1'b1; tick(1); valid = 1'b0; tick(1); valid = 1'b1; tick(1);
      valid = 1'b0; tick(1); valid = 1'b1; tick(15);
      valid = 1'b0; tick(2); valid = 1'b1; tick(2); valid = 1'b0; tick(2);
      valid = 1'b1; tick(1); valid = 1'b0; tick(12);
      check("bounce_events", ev_cnt - e0, 1);
      check("bounce_digit", digits[3:0], 4'd8);

      // value change while held, then new press of 6
      e0 = ev_cnt;
      valid = 1'b1; number = 4'd3; tick(10);
      number = 4'd6; tick(10);
      valid = 1'b0; tick(12);
      check("held_events", ev_cnt - e0, 1);
      check("held_digit", digits[3:0], 4'd3);
      press(6, 10, 12);
      check("press6_digit", digits[3:0], 4'd6);

      // buffer 0836 -> 8369 full, ack, refill to 9021
      press(9, 10, 12);
      ack = 1'b1; tick(1); ack = 1'b0;
      press(9, 10, 12); press(0, 10, 12); press(2, 10, 12); press(1, 10, 12);
      check("full_9021", digits, 16'h9021);

      // ack lands on the same edge as the accept of 4
      valid = 1'b1; number = 4'd4;
      tick(6);
      ack = 1'b1; tick(1); ack = 1'b0;
      check("coll_digits", digits, 16'h0004);
      check("coll_count", count, 3'd1);
      check("coll_ready", ready, 1'b0);
      check("coll_event", key_event, 1'b1);
      check("coll_drop", dropped, 1'b0);
      tick(5);
      valid = 1'b0; tick(12);

      // reset mid press-debounce, key still held afterwards
      valid = 1'b1; number = 4'd2; tick(4);
      reset = 1'b1; tick(1);
      check("rstpd_digits", digits, 16'h0);
      check("rstpd_count", count, 3'd0);
      reset = 1'b0;
      measure_latency("rst_latency");
      tick(5);
      // reset mid hold: release afterwards must not produce an event
      reset = 1'b1; tick(2); reset = 1'b0;
      e0 = ev_cnt;
      valid = 1'b0; tick(12);
      check("rsthold_events", ev_cnt - e0, 0);

      // out-of-range code
      e0 = ev_cnt;
      press(12, 15, 10);
      check("code_c_events", ev_cnt - e0, 0);

      // randomized phase
      rand_ack = 1'b1;
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            press($urandom_range(0, 9), $urandom_range(2, 12), $urandom_range(3, 12));
         end else if (r <= 6) begin
            for (int k = 0; k < $urandom_range(3, 14); k++) begin
               valid  = $urandom_range(0, 1) == 1;
               number = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'd7;
               tick(1);
            end
            valid = 1'b0; tick(8);
         end else if (r == 7) begin
            press($urandom_range(10, 15), $urandom_range(4, 10), 4);
         end else if (r == 8) begin
            valid = 1'b1; number = 4'($urandom_range(0, 9)); tick(8);
            valid = 1'b0; tick($urandom_range(1, 4));
            valid = 1'b1; number = 4'($urandom_range(0, 15)); tick(6);
            valid = 1'b0; tick(10);
         end else begin
            valid = 1'b1; number = 4'($urandom_range(0, 9)); tick($urandom_range(1, 8));
            reset = 1'b1; tick($urandom_range(1, 3)); reset = 1'b0;
            tick($urandom_range(1, 10));
            valid = 1'b0; tick(8);
         end
      end
      rand_ack = 1'b0; ack = 1'b0;
      tick(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
